mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback formatter for the RV32I trap core. Captures the memory-stage result and aligns and sign-extends load data. Selects the writeback source and drives the register-file write port: reg_write, wr_reg and wr_data. Also supplies forwarding values and a trap-aware retire indication.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RESET_PC, 32'h0000_0000, value loaded into wb_pc on reset.

Ports:
clk  in  1  core clock; all state updates on posedge.
rst  in  1  synchronous, active-low reset.
stall  in  1  hold all WB registers.
flush  in  1  replace the captured entry with a bubble.
mem_valid  in  1  the MEM entry is a real instruction.
mem_pc  in  32  PC of the MEM instruction.
mem_alu_result  in  32  ALU result; bits [1:0] are the load byte offset.
mem_rdata  in  32  raw word read from data memory.
mem_csr_data  in  32  CSR read or immediate data.
mem_funct3  in  3  load size and sign.
mem_wb_sel  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 CSR/imm.
mem_rd  in  5  destination register.
mem_reg_write  in  1  the instruction writes rd.
mem_trap  in  1  the MEM instruction raised a trap; kill its writeback.
wb_valid  out  1  the WB entry is valid.
wb_pc  out  32  PC of the WB entry.
wb_reg_write  out  1  to the register file reg_write.
wb_rd  out  5  to the register file wr_reg.
wb_wr_data  out  32  to the register file wr_data; also the forwarding value.
wb_load_misaligned  out  1  one-cycle flag for a misaligned load in WB.
wb_instret  out  64  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (rst==0 at posedge): every output is 0, except wb_pc, which takes RESET_PC. Reset has priority over flush and stall and aborts any entry mid-flight.
- Update priority at each posedge: reset, then flush, then stall, then capture.
- flush==1: wb_valid=0, wb_reg_write=0, wb_load_misaligned=0. wb_pc, wb_rd and wb_wr_data take don't-care values; the bench checks only the write enables. Flush overrides a simultaneous stall.
- stall==1 with flush==0: all outputs hold their values. The held wb_reg_write stays asserted, so the register file rewrites the same value; this is harmless.
- Capture: latency is 1 cycle from MEM inputs to WB outputs. All outputs are registered; there is no combinational path from inputs to outputs.
- wb_reg_write = mem_valid & mem_reg_write & ~mem_trap & (mem_rd!=0) & ~misaligned.
- Writeback data selection:
  - 00: mem_alu_result.
  - 10: mem_pc+4, with 32-bit wrap (32'hFFFF_FFFC gives 0).
  - 11: mem_csr_data.
  - 01: load-formatted data, described below.
- Load formatting, with off = mem_alu_result[1:0]:
  - funct3 000 LB: sign-extend mem_rdata byte[off].
  - funct3 100 LBU: zero-extend mem_rdata byte[off].
  - funct3 001 LH: sign-extend the halfword at off; off[1] selects the upper halfword.
  - funct3 101 LHU: zero-extend the halfword at off.
  - funct3 010 LW: the whole word.
  - funct3 011, 110 and 111 are treated as LW.
- Misaligned means wb_sel==01 and either halfword with off[0]==1, or word with off!=0.
  - A misaligned load sets wb_load_misaligned=1 for the WB cycle and suppresses wb_reg_write.
  - wb_valid still reflects mem_valid.
- mem_trap==1 suppresses wb_reg_write and wb_load_misaligned; wb_valid stays = mem_valid.
- A bubble (mem_valid==0) gives wb_reg_write=0 and wb_load_misaligned=0.

Optional Feature:
WB_RETIRE_CNT_EN
- Defined: a 64-bit counter drives wb_instret. It increments by 1 at each capture posedge (no reset, flush or stall) where mem_valid & ~mem_trap & ~misaligned.
  - It wraps from 2^64-1 to 0.
  - It resets to 0.
  - It holds during stall and flush.
- Undefined: wb_instret is tied to 64'd0 and no counter logic is built.

Test Plan:
- Reset: rst=0 for 2 cycles while mem_valid=1, mem_reg_write=1, mem_rd=5 are driven -> all outputs 0, wb_pc=RESET_PC; the first capture after rst=1 appears 1 cycle later.
- LB, sign/zero: mem_rdata=32'h80FF7F01, alu[1:0]=3, funct3=000 -> wb_wr_data=32'hFFFFFF80. The same with funct3=100 -> 32'h00000080. LHU with off=2 -> 32'h000080FF.
- Misaligned and rd=0: LW with off=2 -> wb_reg_write=0, wb_load_misaligned=1 for one cycle. ALU op with mem_rd=0 -> wb_reg_write=0.
- JAL link: wb_sel=10, mem_pc=32'hFFFFFFFC -> wb_wr_data=0. wb_sel=10, mem_pc=32'h100 -> 32'h104.
- Stall/flush: capture an ALU write of x7=32'hDEAD; stall=1 for 3 cycles while the inputs change -> outputs unchanged. Then stall=1 and flush=1 together -> wb_valid=0, wb_reg_write=0.
- Trap and retire count (macro defined): 4 valid ALU ops, the third with mem_trap=1 -> wb_instret=3; the trapped op has wb_reg_write=0. With the macro undefined -> wb_instret stays 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment and writeback select.
// Optional: `define WB_RETIRE_CNT_EN to build the 64-bit retire counter.
module mem_wb_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] mem_pc,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] mem_csr_data,
  input  logic [2:0]      mem_funct3,
  input  logic [1:0]      mem_wb_sel,
  input  logic [4:0]      mem_rd,
  input  logic            mem_reg_write,
  input  logic            mem_trap,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_pc,
  output logic            wb_reg_write,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_wr_data,
  output logic            wb_load_misaligned,
  output logic [63:0]     wb_instret
);

  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] wr_data_d;
  logic            is_load;
  logic            misaligned;
  logic            reg_write_d;
  logic            mis_flag_d;
  logic            capture;

  assign off     = mem_alu_result[1:0];
  assign is_load = mem_wb_sel == 2'b01;
  assign capture = !flush && !stall;

  always_comb begin
    ld_byte = mem_rdata[7:0];
    unique case (off)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off[1] ? mem_rdata[31:16]
                     : mem_rdata[15:0];
  end

  // Reserved funct3 encodings fall through to a full word.
  always_comb begin
    ld_data = mem_rdata;
    case (mem_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (is_load) begin
      if (mem_funct3[1])
        misaligned = off != 2'b00;
      else if (mem_funct3[0])
        misaligned = off[0];
    end
  end

  always_comb begin
    wr_data_d = mem_alu_result;
    unique case (mem_wb_sel)
      2'b00: wr_data_d = mem_alu_result;
      2'b01: wr_data_d = ld_data;
      2'b10: wr_data_d = mem_pc + 32'd4;
      2'b11: wr_data_d = mem_csr_data;
    endcase
  end

  assign reg_write_d = mem_valid && mem_reg_write
                    && !mem_trap && (mem_rd != 5'd0)
                    && !misaligned;
  assign mis_flag_d  = mem_valid && !mem_trap
                    && misaligned;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid           <= 1'b0;
      wb_pc              <= RESET_PC;
      wb_reg_write       <= 1'b0;
      wb_rd              <= 5'd0;
      wb_wr_data         <= '0;
      wb_load_misaligned <= 1'b0;
    end else if (flush) begin
      wb_valid           <= 1'b0;
      wb_reg_write       <= 1'b0;
      wb_load_misaligned <= 1'b0;
    end else if (capture) begin
      wb_valid           <= mem_valid;
      wb_pc              <= mem_pc;
      wb_reg_write       <= reg_write_d;
      wb_rd              <= mem_rd;
      wb_wr_data         <= wr_data_d;
      wb_load_misaligned <= mis_flag_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret_q;
  logic        retire;

  assign retire = capture && mem_valid
               && !mem_trap && !misaligned;

  always_ff @(posedge clk) begin
    if (!rst)
      instret_q <= '0;
    else if (retire)
      instret_q <= instret_q + 64'd1;
  end

  assign wb_instret = instret_q;
`else
  assign wb_instret = 64'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised and directed bench for mem_wb_stage.
// Reference model works from load size and byte offsets directly.
module tb_mem_wb_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
`ifdef WB_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        m_valid;
  logic [31:0] m_pc, m_alu, m_rdata, m_csr;
  logic [2:0]  m_f3;
  logic [1:0]  m_sel;
  logic [4:0]  m_rd;
  logic        m_rw, m_trap;
  logic        wb_valid, wb_reg_write, wb_mis;
  logic [31:0] wb_pc, wb_wr_data;
  logic [4:0]  wb_rd;
  logic [63:0] wb_instret;

  int errors = 0;
  int checks = 0;

  logic        e_valid, e_rw, e_mis, e_dc;
  logic [31:0] e_pc, e_data;
  logic [4:0]  e_rd;
  longint unsigned e_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(m_valid), .mem_pc(m_pc),
    .mem_alu_result(m_alu), .mem_rdata(m_rdata),
    .mem_csr_data(m_csr), .mem_funct3(m_f3),
    .mem_wb_sel(m_sel), .mem_rd(m_rd),
    .mem_reg_write(m_rw), .mem_trap(m_trap),
    .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_wr_data(wb_wr_data),
    .wb_load_misaligned(wb_mis),
    .wb_instret(wb_instret)
  );

  function automatic void model_next();
    int unsigned o, sz;
    logic [31:0] d, v;
    bit mis;
    if (!rst) begin
      e_valid = 0; e_pc = RST_PC; e_rw = 0;
      e_rd = 0; e_data = 0; e_mis = 0;
      e_dc = 0; e_cnt = 0;
    end else if (flush) begin
      e_valid = 0; e_rw = 0; e_mis = 0; e_dc = 1;
    end else if (!stall) begin
      o  = m_alu % 4;
      sz = m_f3[1] ? 4 : (m_f3[0] ? 2 : 1);
      mis = (m_sel == 2'd1) && ((o % sz) != 0);
      case (m_sel)
        2'd0: d = m_alu;
        2'd2: d = m_pc + 32'd4;
        2'd3: d = m_csr;
        default: begin
          if (sz == 4) d = m_rdata;
          else if (sz == 2) begin
            v = (m_rdata >> (16 * (o / 2))) & 32'hFFFF;
            if (!m_f3[2] && v >= 32'h8000)
              v = v - 32'h10000;
            d = v;
          end else begin
            v = (m_rdata >> (8 * o)) & 32'hFF;
            if (!m_f3[2] && v >= 32'h80)
              v = v - 32'h100;
            d = v;
          end
        end
      endcase
      e_valid = m_valid;
      e_pc    = m_pc;
      e_rd    = m_rd;
      e_data  = d;
      e_rw    = m_valid && m_rw && !m_trap
             && m_rd != 0 && !mis;
      e_mis   = m_valid && !m_trap && mis;
      e_dc    = 0;
      if (m_valid && !m_trap && !mis)
        e_cnt = e_cnt + 1;
    end
  endfunction

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(
    input logic v, input logic [31:0] pc,
    input logic [31:0] alu, input logic [31:0] rd_w,
    input logic [31:0] csr, input logic [2:0] f3,
    input logic [1:0] sel, input logic [4:0] rd,
    input logic rw, input logic trap
  );
    m_valid = v; m_pc = pc; m_alu = alu;
    m_rdata = rd_w; m_csr = csr; m_f3 = f3;
    m_sel = sel; m_rd = rd; m_rw = rw; m_trap = trap;
  endtask

  task automatic test_reset();
    rst = 0; stall = 0; flush = 0;
    set_in(1, 32'h40, 32'h1234, 0, 0, 3'b010,
           2'b00, 5'd5, 1, 0);
    tick(); tick();
    checks += 6;
    if (wb_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid got=%b exp=0", wb_valid); end
    if (wb_pc !== RST_PC) begin errors++;
      $display("FAIL rst_pc got=%h exp=%h", wb_pc, RST_PC); end
    if (wb_reg_write !== 1'b0) begin errors++;
      $display("FAIL rst_rw got=%b exp=0", wb_reg_write); end
    if (wb_rd !== 5'd0 || wb_wr_data !== 32'd0) begin errors++;
      $display("FAIL rst_rd_data got=%0d/%h exp=0/0",
               wb_rd, wb_wr_data); end
    if (wb_mis !== 1'b0) begin errors++;
      $display("FAIL rst_mis got=%b exp=0", wb_mis); end
    if (wb_instret !== 64'd0) begin errors++;
      $display("FAIL rst_instret got=%0d exp=0", wb_instret); end
    rst = 1;
    #2;
    checks++;
    if (wb_valid !== 1'b0) begin errors++;
      $display("FAIL rst_release_early got=%b exp=0", wb_valid); end
    @(negedge clk);
    tick();
    checks += 3;
    if (wb_valid !== 1'b1) begin errors++;
      $display("FAIL first_capture_valid got=%b exp=1", wb_valid); end
    if (wb_rd !== 5'd5 || wb_reg_write !== 1'b1) begin errors++;
      $display("FAIL first_capture_rd got=%0d/%b exp=5/1",
               wb_rd, wb_reg_write); end
    if (wb_wr_data !== 32'h1234 || wb_pc !== 32'h40) begin errors++;
      $display("FAIL first_capture_data got=%h/%h exp=1234/40",
               wb_wr_data, wb_pc); end
  endtask

  task automatic test_load_format();
    logic [2:0]  f3s [5];
    logic [31:0] als [5];
    logic [31:0] exp [5];
    f3s = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
    als = '{32'h3, 32'h7, 32'h2, 32'h2, 32'h100};
    exp = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF,
            32'hFFFF80FF, 32'h80FF7F01};
    for (int i = 0; i < 5; i++) begin
      set_in(1, 32'h200, als[i], 32'h80FF7F01, 0,
             f3s[i], 2'b01, 5'd3, 1, 0);
      tick();
      checks++;
      if (wb_wr_data !== exp[i] || wb_reg_write !== 1'b1
          || wb_mis !== 1'b0) begin
        errors++;
        $display("FAIL load_fmt[%0d] got=%h/%b/%b exp=%h/1/0",
                 i, wb_wr_data, wb_reg_write, wb_mis, exp[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    set_in(1, 32'h300, 32'h2, 32'hCAFEF00D, 0,
           3'b010, 2'b01, 5'd9, 1, 0);
    tick();
    checks++;
    if (wb_reg_write !== 1'b0 || wb_mis !== 1'b1
        || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_lw got=%b/%b/%b exp=0/1/1",
               wb_reg_write, wb_mis, wb_valid);
    end
    set_in(1, 32'h304, 32'h55, 0, 0,
           3'b000, 2'b00, 5'd0, 1, 0);
    tick();
    checks++;
    if (wb_mis !== 1'b0 || wb_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL rd0_after_mis got=%b/%b exp=0/0",
               wb_mis, wb_reg_write);
    end
  endtask

  task automatic test_jal();
    set_in(1, 32'hFFFFFFFC, 0, 0, 0, 3'b000,
           2'b10, 5'd1, 1, 0);
    tick();
    checks++;
    if (wb_wr_data !== 32'd0) begin errors++;
      $display("FAIL jal_wrap got=%h exp=0", wb_wr_data); end
    m_pc = 32'h100;
    tick();
    checks++;
    if (wb_wr_data !== 32'h104 || wb_reg_write !== 1'b1) begin
      errors++;
      $display("FAIL jal_link got=%h/%b exp=104/1",
               wb_wr_data, wb_reg_write);
    end
  endtask

  task automatic test_stall_flush();
    set_in(1, 32'h500, 32'hDEAD, 0, 0, 3'b000,
           2'b00, 5'd7, 1, 0);
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, $urandom, $urandom, $urandom, $urandom,
             3'($urandom), 2'($urandom), 5'($urandom),
             1, 0);
      tick();
      checks++;
      if (wb_wr_data !== 32'hDEAD || wb_rd !== 5'd7
          || wb_reg_write !== 1'b1 || wb_pc !== 32'h500) begin
        errors++;
        $display("FAIL stall_hold[%0d] got=%h/%0d/%b exp=dead/7/1",
                 i, wb_wr_data, wb_rd, wb_reg_write);
      end
    end
    flush = 1;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush got=%b/%b exp=0/0",
               wb_valid, wb_reg_write);
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_retire();
    rst = 0;
    tick();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'h600 + 4 * i, 32'h10 + i, 0, 0,
             3'b000, 2'b00, 5'd4, 1, i == 2);
      tick();
      if (i == 2) begin
        checks++;
        if (wb_reg_write !== 1'b0 || wb_valid !== 1'b1) begin
          errors++;
          $display("FAIL trap_kill got=%b/%b exp=0/1",
                   wb_reg_write, wb_valid);
        end
      end
    end
    m_valid = 0;
    tick();
    checks++;
    if (wb_instret !== (CNT_EN ? 64'd3 : 64'd0)) begin
      errors++;
      $display("FAIL retire_cnt got=%0d exp=%0d",
               wb_instret, CNT_EN ? 3 : 0);
    end
  endtask

  task automatic test_random();
    logic [63:0] ecnt;
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_in($urandom_range(0, 7) != 0, $urandom,
             $urandom, $urandom, $urandom,
             3'($urandom), 2'($urandom),
             ($urandom_range(0, 7) == 0) ? 5'd0
                                         : 5'($urandom),
             1'($urandom),
             $urandom_range(0, 7) == 0);
      tick();
      ecnt = CNT_EN ? 64'(e_cnt) : 64'd0;
      checks++;
      if (wb_valid !== e_valid || wb_reg_write !== e_rw
          || wb_mis !== e_mis || wb_instret !== ecnt) begin
        errors++;
        $display("FAIL rand_ctl[%0d] got=%b%b%b/%0d exp=%b%b%b/%0d",
                 n, wb_valid, wb_reg_write, wb_mis, wb_instret,
                 e_valid, e_rw, e_mis, ecnt);
      end
      if (!e_dc) begin
        checks++;
        if (wb_pc !== e_pc || wb_rd !== e_rd
            || wb_wr_data !== e_data) begin
          errors++;
          $display("FAIL rand_data[%0d] got=%h/%0d/%h exp=%h/%0d/%h",
                   n, wb_pc, wb_rd, wb_wr_data,
                   e_pc, e_rd, e_data);
        end
      end
    end
    stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_load_format();
    test_misaligned();
    test_jal();
    test_stall_flush();
    test_retire();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
